// File: rtl/rob_if.sv
// Dispatch / CDB / commit bundle of the reorder buffer.
// The ROB side is the slave; dispatch, CDB and the LSU drive the master side.
interface rob_if #(
    parameter int DEPTH = 6,
    parameter int TAG_W = 4
);
    logic                       alloc_valid;
    logic [1:0]                 alloc_op;
    logic [4:0]                 alloc_rd;
    logic [TAG_W-1:0]           alloc_tag;
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [31:0]                cdb_val;
    logic                       cdb_mispred;
    logic [DEPTH-1:0]           rob_busy;
    logic [DEPTH-1:0][31:0]     rob_vals;
    logic                       commit_valid;
    logic [TAG_W-1:0]           commit_tag;
    logic [1:0]                 commit_op;
    logic [4:0]                 commit_rd;
    logic [31:0]                commit_val;
    logic                       st_ack;
    logic                       flush;

    modport master (
        output alloc_valid, alloc_op, alloc_rd,
        output cdb_valid, cdb_tag, cdb_val, cdb_mispred,
        output st_ack,
        input  alloc_tag, rob_busy, rob_vals,
        input  commit_valid, commit_tag, commit_op, commit_rd, commit_val,
        input  flush
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_val, cdb_mispred,
        input  st_ack,
        output alloc_tag, rob_busy, rob_vals,
        output commit_valid, commit_tag, commit_op, commit_rd, commit_val,
        output flush
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, in-order retire,
// store-commit handshake and flush on a mispredicted branch at head.
module reorder_buffer #(
    parameter int DEPTH = 6,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    rob_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] OP_ST = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] mispred_q;
    logic [1:0]       op_q  [DEPTH];
    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic             full;
    logic             do_alloc;
    logic             do_commit;
    logic             do_flush;
    logic             cdb_hit;
    logic [TAG_W-1:0] cdb_off;
    logic [PTR_W-1:0] cdb_idx;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Tag offer uses registered count only; a same-cycle commit frees nothing yet.
    assign full          = (count_q == CNT_W'(DEPTH));
    assign bus.alloc_tag = full ? '0 : TAG_W'(tail_q) + TAG_W'(1);
    assign do_alloc      = bus.alloc_valid && !full && !do_flush;

    assign cdb_off = bus.cdb_tag - TAG_W'(1);
    assign cdb_idx = PTR_W'(cdb_off);
    assign cdb_hit = bus.cdb_valid
                  && (bus.cdb_tag != '0)
                  && (bus.cdb_tag <= TAG_W'(DEPTH))
                  && valid_q[cdb_idx]
                  && !done_q[cdb_idx];

    assign do_commit = valid_q[head_q] && done_q[head_q]
                    && ((op_q[head_q] != OP_ST) || bus.st_ack);
    assign do_flush  = do_commit && (op_q[head_q] == OP_BR) && mispred_q[head_q];

    assign bus.commit_valid = do_commit;
    assign bus.commit_tag   = TAG_W'(head_q) + TAG_W'(1);
    assign bus.commit_op    = op_q[head_q];
    assign bus.commit_rd    = rd_q[head_q];
    assign bus.commit_val   = val_q[head_q];
    assign bus.flush        = do_flush;
    assign bus.rob_busy     = valid_q & ~done_q;

    always_comb begin
        bus.rob_vals = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rob_vals[i] = val_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
        end else if (do_flush) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (cdb_hit) begin
                done_q[cdb_idx]    <= 1'b1;
                val_q[cdb_idx]     <= bus.cdb_val;
                mispred_q[cdb_idx] <= bus.cdb_mispred;
            end
            if (do_commit) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= wrap_inc(head_q);
            end
            // Head and tail only coincide when empty or full, so no slot conflict.
            if (do_alloc) begin
                valid_q[tail_q]   <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                mispred_q[tail_q] <= 1'b0;
                op_q[tail_q]      <= bus.alloc_op;
                rd_q[tail_q]      <= bus.alloc_rd;
                val_q[tail_q]     <= '0;
                tail_q            <= wrap_inc(tail_q);
            end
            if (do_alloc && !do_commit) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_alloc && do_commit) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule
